// File: rtl/addsub_iter_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
// Optional saturation is selected by ADDSUB_ITER_SATURATE_EN in addsub_iter.sv.
package addsub_iter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int unsigned LIMIT_W = 64;

    // Signed limit of a 'width'-bit word: 0111..1 when neg == 0, 1000..0 when neg == 1.
    function automatic logic [LIMIT_W-1:0] signed_limit(input int unsigned width, input logic neg);
        logic [LIMIT_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LIMIT_W; i++) begin
            if (i + 1 < width) begin
                r[i] = ~neg;
            end else if (i + 1 == width) begin
                r[i] = neg;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_iter_if.sv
// Operand/result handshake bundle for addsub_iter.
interface addsub_iter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             z;

    modport master (
        output in_valid, a, b, m, out_ready,
        input  in_ready, out_valid, s, c, v, z
    );

    modport slave (
        input  in_valid, a, b, m, out_ready,
        output in_ready, out_valid, s, c, v, z
    );
endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit adder slice; also exposes the carry into its top bit
// so the caller can form two's-complement overflow on the final digit.
module addsub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    if (DIGIT == 1) begin : g_bit
        assign c_msb_in = cin;
        assign sum      = x ^ y ^ cin;
    end else begin : g_wide
        // Top bit holds the carry out of the lower DIGIT-1 bits.
        logic [DIGIT-1:0] low;
        assign low      = {1'b0, x[DIGIT-2:0]} + {1'b0, y[DIGIT-2:0]} + {{(DIGIT-1){1'b0}}, cin};
        assign c_msb_in = low[DIGIT-1];
        assign sum      = {x[DIGIT-1] ^ y[DIGIT-1] ^ low[DIGIT-1], low[DIGIT-2:0]};
    end

    assign cout = (x[DIGIT-1] & y[DIGIT-1]) | (c_msb_in & (x[DIGIT-1] ^ y[DIGIT-1]));

endmodule

// File: rtl/addsub_iter.sv
// Multi-cycle add/subtract, DIGIT bits per clock, LSB digit first, with handshakes.
// Define ADDSUB_ITER_SATURATE_EN to clamp overflowing results to the signed limit.
module addsub_iter
    import addsub_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_iter_if.slave bus
);

    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("addsub_iter: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic [DIGIT-1:0]       dsum;
    logic                   dcout;
    logic                   dmsb;
    logic [WIDTH+DIGIT-1:0] res_shift;
    logic [WIDTH-1:0]       res_next;
    logic [WIDTH-1:0]       s_fin;
`ifdef ADDSUB_ITER_SATURATE_EN
    logic [LIMIT_W-1:0]     lim;
`endif

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .cin      (carry_q),
        .sum      (dsum),
        .cout     (dcout),
        .c_msb_in (dmsb)
    );

    // Result fills from the top so it is aligned once all NDIG digits are in.
    assign res_shift = {dsum, res_q};
    assign res_next  = res_shift[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
`ifdef ADDSUB_ITER_SATURATE_EN
        // On the final digit a_q[DIGIT-1] is still the latched MSB of operand a.
        lim   = signed_limit(WIDTH, a_q[DIGIT-1]);
        s_fin = (dmsb ^ dcout) ? lim[WIDTH-1:0] : res_next;
`else
        s_fin = res_next;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.a;
                    b_d        = bus.b ^ {WIDTH{bus.m == MODE_SUB}};
                    carry_d    = (bus.m == MODE_SUB);
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_next;
                carry_d = dcout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    s_d         = s_fin;
                    c_d         = dcout;
                    v_d         = dmsb ^ dcout;
                    z_d         = (s_fin == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            c_q         <= c_d;
            v_q         <= v_d;
            z_q         <= z_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
    assign bus.z         = z_q;

endmodule

// File: tb/tb_addsub_iter.sv
// Bench for addsub_iter: directed table and corner sequences on 16/4, random sweeps on 16/1, 16/16, 8/2.
module tb_addsub_iter;

`ifdef ADDSUB_ITER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rst_sw_n;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- main DUT: WIDTH=16, DIGIT=4 ----------------
    addsub_iter_if #(.WIDTH(16)) mi ();
    addsub_iter #(.WIDTH(16), .DIGIT(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(mi.slave));

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] s_raw;
        logic [15:0] s_sat;
        logic        c;
        logic        v;
        logic        z_raw;
        logic        z_sat;
    } vec_t;

    exp_t mq[$];
    vec_t vecs[12];

    task automatic main_send(input logic [15:0] a, input logic [15:0] b, input logic m, input exp_t e);
        int unsigned n;
        n = 0;
        while (!mi.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", mi.in_ready, 1);
        mi.a        = a;
        mi.b        = b;
        mi.m        = m;
        mi.in_valid = 1'b1;
        mq.push_back(e);
        @(negedge clk);
        mi.in_valid = 1'b0;
        mi.a        = 16'($urandom);
        mi.b        = 16'($urandom);
    endtask

    // n0: negedges already spent since the one right after the accepting edge.
    task automatic main_recv(input int unsigned n0, input int unsigned hold);
        int unsigned n;
        exp_t e;
        n = n0;
        while (!mi.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 4);
        if (mq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 exp=1");
            e = '0;
        end else begin
            e = mq.pop_front();
        end
        chk("s", mi.s, e.s);
        chk("c", mi.c, e.c);
        chk("v", mi.v, e.v);
        chk("z", mi.z, e.z);
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", mi.out_valid, 1);
            chk("hold_in_ready", mi.in_ready, 0);
            chk("hold_s", mi.s, e.s);
            chk("hold_c", mi.c, e.c);
            chk("hold_v", mi.v, e.v);
            chk("hold_z", mi.z, e.z);
        end
        mi.out_ready = 1'b1;
        @(negedge clk);
        mi.out_ready = 1'b0;
        chk("post_ack_out_valid", mi.out_valid, 0);
        chk("post_ack_in_ready", mi.in_ready, 1);
    endtask

    function automatic exp_t vec_exp(input vec_t t);
        exp_t e;
        e.s = SAT ? t.s_sat : t.s_raw;
        e.c = t.c;
        e.v = t.v;
        e.z = SAT ? t.z_sat : t.z_raw;
        return e;
    endfunction

    initial begin
        exp_t e;
        int unsigned n;
        rst_n        = 1'b0;
        rst_sw_n     = 1'b0;
        mi.in_valid  = 1'b0;
        mi.a         = '0;
        mi.b         = '0;
        mi.m         = 1'b0;
        mi.out_ready = 1'b0;

        //           a         b         m     s_raw     s_sat     c     v     z_raw z_sat
        vecs[0]  = '{16'h0004, 16'h0003, 1'b0, 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{16'h0004, 16'h0003, 1'b1, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{16'h0003, 16'h0004, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", mi.in_ready, 1);
        chk("rst_out_valid", mi.out_valid, 0);
        chk("rst_s", mi.s, 0);
        chk("rst_c", mi.c, 0);
        chk("rst_v", mi.v, 0);
        chk("rst_z", mi.z, 0);
        rst_n    = 1'b1;
        rst_sw_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            main_send(vecs[i].a, vecs[i].b, vecs[i].m, vec_exp(vecs[i]));
            main_recv(0, 0);
        end

        // Backpressure in DONE, then a fresh op with in_valid pulses during RUN.
        main_send(16'h7FFF, 16'h0001, 1'b0, vec_exp(vecs[3]));
        main_recv(0, 5);
        e = '{s: 16'h3333, c: 1'b0, v: 1'b0, z: 1'b0};
        main_send(16'h1111, 16'h2222, 1'b0, e);
        mi.a        = 16'hFFFF;
        mi.b        = 16'hFFFF;
        mi.m        = 1'b1;
        mi.in_valid = 1'b1;
        chk("run_in_ready", mi.in_ready, 0);
        @(negedge clk);
        chk("run_in_ready2", mi.in_ready, 0);
        @(negedge clk);
        mi.in_valid = 1'b0;
        main_recv(2, 0);

        // Reset during RUN digit 2.
        e = '{s: 16'h3579, c: 1'b0, v: 1'b0, z: 1'b0};
        main_send(16'h1234, 16'h2345, 1'b0, e);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", mi.out_valid, 0);
        chk("midrst_in_ready", mi.in_ready, 1);
        chk("midrst_s", mi.s, 0);
        chk("midrst_c", mi.c, 0);
        chk("midrst_v", mi.v, 0);
        chk("midrst_z", mi.z, 0);
        mq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst_out_valid", mi.out_valid, 0);
            chk("postrst_in_ready", mi.in_ready, 1);
        end
        main_send(16'h00FF, 16'h0001, 1'b0, vec_exp(vecs[11]));
        main_recv(0, 0);

        n = 0;
        while (done_cnt < 3 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("sweeps_complete", done_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- random sweeps: 16/1, 16/16, 8/2 ----------------
    for (genvar k = 0; k < 3; k++) begin : g_sw
        localparam int unsigned W = (k == 2) ? 8 : 16;
        localparam int unsigned D = (k == 0) ? 1 : ((k == 1) ? 16 : 2);
        localparam int unsigned N = W / D;

        addsub_iter_if #(.WIDTH(W)) sif ();
        addsub_iter #(.WIDTH(W), .DIGIT(D)) u_dut (.clk(clk), .rst_n(rst_sw_n), .bus(sif.slave));

        logic [W+2:0] q[$];

        initial begin
            logic [W-1:0] a, b, bb, sr;
            logic [W:0]   full;
            logic         md, cc, vv, zz;
            logic [W+2:0] e;
            int unsigned  n;
            sif.in_valid  = 1'b0;
            sif.a         = '0;
            sif.b         = '0;
            sif.m         = 1'b0;
            sif.out_ready = 1'b0;
            wait (rst_sw_n);
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                a  = W'($urandom);
                b  = W'($urandom);
                md = 1'($urandom);
                if (i % 5 == 0) a = {1'b0, {(W-1){1'b1}}};
                if (i % 5 == 1) a = {1'b1, {(W-1){1'b0}}};
                if (i % 7 == 0) b = a;
                bb   = md ? ~b : b;
                full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, md};
                sr   = full[W-1:0];
                cc   = full[W];
                vv   = (a[W-1] == bb[W-1]) && (sr[W-1] != a[W-1]);
                if (SAT && vv) sr = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                zz   = (sr == '0);

                n = 0;
                while (!sif.in_ready && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk($sformatf("sw%0d_in_ready", k), sif.in_ready, 1);
                sif.a        = a;
                sif.b        = b;
                sif.m        = md;
                sif.in_valid = 1'b1;
                q.push_back({sr, cc, vv, zz});
                @(negedge clk);
                sif.in_valid = 1'b0;
                n = 0;
                while (!sif.out_valid && n < N + 20) begin
                    @(negedge clk);
                    n++;
                end
                chk($sformatf("sw%0d_latency op%0d", k, i), n, N);
                e = (q.size() != 0) ? q.pop_front() : '0;
                chk($sformatf("sw%0d_s op%0d", k, i), sif.s, e[W+2:3]);
                chk($sformatf("sw%0d_c op%0d", k, i), sif.c, e[2]);
                chk($sformatf("sw%0d_v op%0d", k, i), sif.v, e[1]);
                chk($sformatf("sw%0d_z op%0d", k, i), sif.z, e[0]);
                sif.out_ready = 1'b1;
                @(negedge clk);
                sif.out_ready = 1'b0;
            end
            done_cnt++;
        end
    end

endmodule
